// File: rtl/sa_psum_deskew.sv
// Drain-side collector for the systolic array: removes the per-column skew from
// the saturated partial sums, checks row alignment and buffers rows in an FWFT FIFO.
module sa_psum_deskew #(
    parameter int NUM_COLS      = 4,
    parameter int ADD_DATAWIDTH = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              i_clear,
    input  logic [NUM_COLS-1:0]               i_psum_valid,
    input  logic [NUM_COLS*ADD_DATAWIDTH-1:0] i_psum,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [NUM_COLS*ADD_DATAWIDTH-1:0] o_row,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
    output logic                              o_overflow,
    output logic                              o_skew_err
);
    localparam int W     = ADD_DATAWIDTH;
    localparam int ROW_W = NUM_COLS * W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [NUM_COLS-1:0] dv;
    logic [ROW_W-1:0]    drow;

    // Column c waits NUM_COLS-1-c cycles so every column of a row lines up with the last one.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        localparam int D = NUM_COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign dv[c]          = i_psum_valid[c];
            assign drow[c*W +: W] = i_psum[c*W +: W];
        end else begin : g_dly
            logic [D-1:0]        v_q;
            logic signed [W-1:0] d_q [D];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    v_q <= '0;
                    for (int k = 0; k < D; k++) d_q[k] <= '0;
                end else if (i_clear) begin
                    v_q <= '0;
                    for (int k = 0; k < D; k++) d_q[k] <= '0;
                end else begin
                    v_q[0] <= i_psum_valid[c];
                    d_q[0] <= i_psum[c*W +: W];
                    for (int k = 1; k < D; k++) begin
                        v_q[k] <= v_q[k-1];
                        d_q[k] <= d_q[k-1];
                    end
                end
            end

            assign dv[c]          = v_q[D-1];
            assign drow[c*W +: W] = d_q[D-1];
        end
    end

    logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, skew_q, skew_d;
    logic             row_all, row_any, full, rd_en, wr_en;

    always_comb begin
        row_all  = &dv;
        row_any  = |dv;
        full     = (cnt_q == CNT_W'(FIFO_DEPTH));
        rd_en    = (cnt_q != '0) && i_ready;
        // A full FIFO still takes a row when the head leaves in the same cycle.
        wr_en    = row_all && (!full || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        skew_d   = skew_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            skew_d   = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
            if (row_all && full && !rd_en) ovf_d = 1'b1;
            if (row_any && !row_all) skew_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            skew_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            skew_q   <= skew_d;
            if (i_clear) begin
                for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            end else if (wr_en) begin
                mem_q[wr_ptr_q] <= drow;
            end
        end
    end

    assign o_valid    = (cnt_q != '0);
    assign o_row      = mem_q[rd_ptr_q];
    assign o_count    = cnt_q;
    assign o_overflow = ovf_q;
    assign o_skew_err = skew_q;

endmodule

// File: tb/tb_sa_psum_deskew.sv
// Directed bench for sa_psum_deskew (4 columns, 8-bit psums, depth-4 FIFO).
module tb_sa_psum_deskew;
    localparam int NC    = 4;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int NCYC  = 256;

    logic          clk;
    logic          rstn;
    logic          i_clear;
    logic [NC-1:0] i_psum_valid;
    logic [NC*W-1:0] i_psum;
    logic          o_valid;
    logic          i_ready;
    logic [NC*W-1:0] o_row;
    logic [2:0]    o_count;
    logic          o_overflow;
    logic          o_skew_err;

    sa_psum_deskew #(.NUM_COLS(NC), .ADD_DATAWIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_clear      (i_clear),
        .i_psum_valid (i_psum_valid),
        .i_psum       (i_psum),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_row        (o_row),
        .o_count      (o_count),
        .o_overflow   (o_overflow),
        .o_skew_err   (o_skew_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int s;

    // Row schedule: a row started at cycle s puts column c on the inputs at cycle s+c.
    logic [31:0] st_dat  [NCYC];
    logic [3:0]  st_mask [NCYC];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sched_row(input int start, input logic [31:0] dat, input logic [3:0] mask);
        st_dat[start]  = dat;
        st_mask[start] = mask;
    endtask

    task automatic tick();
        logic [NC-1:0]   v;
        logic [NC*W-1:0] d;
        int              r;
        v = '0;
        d = '0;
        for (int c = 0; c < NC; c++) begin
            r = cyc - c;
            if (r >= 0 && r < NCYC && st_mask[r][c]) begin
                v[c]       = 1'b1;
                d[c*W +: W] = st_dat[r][c*W +: W];
            end
        end
        i_psum_valid = v;
        i_psum       = d;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            st_dat[i]  = '0;
            st_mask[i] = '0;
        end
        rstn = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
        i_psum_valid = '0; i_psum = '0;
        #12;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_row",   64'(o_row),   64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_ovf",   64'(o_overflow), 64'd0);
        check("rst_skew",  64'(o_skew_err), 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;

        // Single row, psum c+1 in column c
        s = cyc;
        sched_row(s, 32'h04030201, 4'hF);
        run(3);
        check("single_pre_valid", 64'(o_valid), 64'd0);
        tick();
        check("single_valid", 64'(o_valid), 64'd1);
        check("single_row",   64'(o_row),   64'h04030201);
        check("single_count", 64'(o_count), 64'd1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("single_drained", 64'(o_valid), 64'd0);

        // Back-pressure: six rows, only four fit
        s = cyc;
        for (int k = 1; k <= 6; k++) sched_row(s + k - 1, 32'h01010101 * k, 4'hF);
        run(7);
        check("bp_full_count", 64'(o_count), 64'd4);
        check("bp_ovf_before", 64'(o_overflow), 64'd0);
        run(2);
        check("bp_count",  64'(o_count), 64'd4);
        check("bp_ovf",    64'(o_overflow), 64'd1);
        check("bp_head",   64'(o_row), 64'h01010101);
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("bp_valid", 64'(o_valid), 64'd1);
            check("bp_order", 64'(o_row), 64'(32'h01010101 * k));
            tick();
        end
        i_ready = 1'b0;
        check("bp_empty",     64'(o_valid), 64'd0);
        check("bp_ovf_stick", 64'(o_overflow), 64'd1);

        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clr_ovf",   64'(o_overflow), 64'd0);
        check("clr_count", 64'(o_count), 64'd0);

        // Full FIFO with read and write on the same edge
        s = cyc;
        for (int j = 1; j <= 5; j++) sched_row(s + j - 1, 32'h10101010 + 32'h01010101 * j, 4'hF);
        run(7);
        check("rw_full_count", 64'(o_count), 64'd4);
        check("rw_full_head",  64'(o_row), 64'h11111111);
        i_ready = 1'b1;
        for (int j = 2; j <= 5; j++) begin
            tick();
            check("rw_head",  64'(o_row), 64'(32'h10101010 + 32'h01010101 * j));
            check("rw_count", 64'(o_count), 64'(6 - j));
        end
        tick();
        i_ready = 1'b0;
        check("rw_empty", 64'(o_valid), 64'd0);
        check("rw_ovf",   64'(o_overflow), 64'd0);

        // Skew error: good row buffered, then a row missing column 1
        s = cyc;
        sched_row(s,     32'h0A0B0C0D, 4'hF);
        sched_row(s + 1, 32'h55555555, 4'b1101);
        run(4);
        check("skew_count_pre", 64'(o_count), 64'd1);
        check("skew_err_pre",   64'(o_skew_err), 64'd0);
        tick();
        check("skew_err",   64'(o_skew_err), 64'd1);
        check("skew_count", 64'(o_count), 64'd1);
        check("skew_head",  64'(o_row), 64'h0A0B0C0D);
        run(2);
        check("skew_count_post", 64'(o_count), 64'd1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("skclr_err",   64'(o_skew_err), 64'd0);
        check("skclr_count", 64'(o_count), 64'd0);
        check("skclr_valid", 64'(o_valid), 64'd0);

        // Saturated extremes pass bit-exact
        s = cyc;
        sched_row(s, 32'h807F807F, 4'hF);
        run(4);
        check("sat_valid", 64'(o_valid), 64'd1);
        check("sat_row",   64'(o_row), 64'h807F807F);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("sat_drained", 64'(o_valid), 64'd0);

        // Asynchronous reset with one row buffered and three in flight
        s = cyc;
        sched_row(s,     32'h21212121, 4'hF);
        sched_row(s + 2, 32'h22222222, 4'hF);
        sched_row(s + 3, 32'h23232323, 4'hF);
        sched_row(s + 4, 32'h24242424, 4'hF);
        run(4);
        check("mid_count", 64'(o_count), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_row",   64'(o_row), 64'd0);
        check("arst_count", 64'(o_count), 64'd0);
        check("arst_ovf",   64'(o_overflow), 64'd0);
        check("arst_skew",  64'(o_skew_err), 64'd0);
        run(4);
        #2;
        rstn = 1'b1;
        run(5);
        check("post_valid", 64'(o_valid), 64'd0);
        check("post_count", 64'(o_count), 64'd0);
        check("post_skew",  64'(o_skew_err), 64'd0);
        s = cyc;
        sched_row(s, 32'h31323334, 4'hF);
        run(3);
        check("fresh_pre_valid", 64'(o_valid), 64'd0);
        tick();
        check("fresh_valid", 64'(o_valid), 64'd1);
        check("fresh_row",   64'(o_row), 64'h31323334);
        check("fresh_count", 64'(o_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_psum_deskew.md
Name: sa_psum_deskew

Overview:
- Drain-side collector at the bottom of the systolic array.
- Takes the per-column saturated partial sums produced by the MAC chain. Column c emits row r at cycle t0+r+c, so each row leaves the array skewed by one cycle per column.
- Removes the skew, reassembles each row as one aligned vector, and buffers rows in a small FIFO.
- Presents buffered rows to the downstream writer over a valid/ready handshake.

Parameters:
- NUM_COLS, 4, number of array columns (>=2)
- ADD_DATAWIDTH, 8, width of one signed psum, equal to the MAC accumulator width
- FIFO_DEPTH, 4, number of aligned rows buffered (power of two, >=2)

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- i_clear  input  1  synchronous flush of all state and flags
- i_psum_valid  input  NUM_COLS  per-column valid; bit c belongs to column c
- i_psum  input  NUM_COLS*ADD_DATAWIDTH  per-column signed psum; column c at bits [c*W +: W]
- o_valid  output  1  head row available
- i_ready  input  1  downstream accepts head row
- o_row  output  NUM_COLS*ADD_DATAWIDTH  aligned row, same packing as i_psum
- o_count  output  $clog2(FIFO_DEPTH+1)  rows currently buffered
- o_overflow  output  1  sticky: an aligned row was dropped because the FIFO was full
- o_skew_err  output  1  sticky: delayed column valids disagreed

Behaviour:
- Reset (rstn=0, asynchronous): all delay stages, FIFO pointers and flags clear. o_valid=0, o_row=0, o_count=0, o_overflow=0, o_skew_err=0. A reset mid-row discards partially aligned data. The first cycle after release behaves as empty.
- Deskew:
  - Column c passes through a registered delay line of depth NUM_COLS-1-c, carrying both valid and data.
  - Column NUM_COLS-1 has zero delay (combinational pass-through).
  - Total deskew register count = NUM_COLS*(NUM_COLS-1)/2 stages.
- Alignment check, evaluated in every cycle on the delayed valids dv[]:
  - All dv high: aligned row present, requests a FIFO write.
  - All dv low: idle.
  - Mixed: no write; o_skew_err set (sticky) at the next edge.
- FIFO behaviour:
  - First-word fall-through.
  - o_valid = (o_count != 0); o_row = head entry.
  - When o_valid=0, o_row shows the last head value (or 0 after reset/clear). Don't-care for checking.
  - Read occurs on a rising edge with o_valid & i_ready.
  - Write occurs on a rising edge with an aligned row & (not full, or read in the same cycle).
- Latency: a row whose last column (NUM_COLS-1) is valid in cycle T is visible at o_row with o_valid=1 in cycle T+1 if the FIFO was empty.
- Throughput: one row per cycle sustained when i_ready=1.
- Full, no read: the aligned row is dropped. o_overflow set (sticky). o_count stays FIFO_DEPTH.
- Full with simultaneous read: write accepted, o_count unchanged, order preserved.
- Empty with i_ready=1: no effect.
- Data rule: psums pass bit-exact. No arithmetic, no re-saturation, signed values unchanged.
- o_valid must not drop while the head is unread. o_row must stay stable while o_valid=1 & i_ready=0.
- i_clear=1 takes priority over a write or read in the same cycle:
  - Empties the FIFO and all delay stages.
  - Clears both sticky flags.
  - o_valid=0 the next cycle.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished via o_count, never by pointer equality alone.

Test Plan (NUM_COLS=4, W=8, FIFO_DEPTH=4):
- Single row: col c valid in cycle 10+c with psum c+1 -> cycle 14: o_valid=1, o_row=0x04030201, o_count=1; i_ready=1 in cycle 14 -> o_valid=0 in cycle 15.
- Back-pressure and overflow: 6 consecutive skewed rows (values 1..6 in every column), i_ready=0 -> o_count=4, o_overflow=1, rows 5 and 6 lost; then i_ready=1 -> rows 1,2,3,4 in order on 4 consecutive cycles, o_overflow stays 1.
- Full with read and write in the same cycle: FIFO full, i_ready=1 and a new row aligns in the same cycle -> o_count stays 4, head advances, new row appears last, o_overflow stays 0.
- Skew error: row with column 1 valid missing -> no FIFO write, o_count unchanged, o_skew_err=1 from the cycle after alignment; i_clear pulse -> o_skew_err=0, o_count=0.
- Saturated values: psums 0x7F (127) and 0x80 (-128) per column -> o_row bit-exact 0x807F807F.
- Reset mid-operation: rstn low during the second of 3 in-flight rows with 1 row buffered -> all outputs 0 immediately (asynchronous); after release, no stale row emerges and a fresh row shows the single-row latency.
